// File: rtl/debug_dump_controller_if.sv
// debug_dump_controller_if: UART command/response and snapshot-mux signals of the debug dump controller
// Ports (as modport views):
//   slave  (controller): in rx_data, rx_done_tick, tx_done_tick, word_in;
//                        out tx_start, tx_data, word_idx, pipe_clk_en, busy
//   master (environment): the mirror of slave
interface debug_dump_controller_if #(
    parameter int IDX_BITS = 6
);
    logic [7:0]          rx_data;
    logic                rx_done_tick;
    logic                tx_done_tick;
    logic                tx_start;
    logic [7:0]          tx_data;
    logic [IDX_BITS-1:0] word_idx;
    logic [31:0]         word_in;
    logic                pipe_clk_en;
    logic                busy;
    modport slave (
        input  rx_data, rx_done_tick, tx_done_tick, word_in,
        output tx_start, tx_data, word_idx, pipe_clk_en, busy
    );
    modport master (
        output rx_data, rx_done_tick, tx_done_tick, word_in,
        input  tx_start, tx_data, word_idx, pipe_clk_en, busy
    );
endinterface

// File: rtl/debug_dump_controller.sv
// debug_dump_controller: debug UART command decoder, pipeline clock gate and snapshot frame sender
// Ports: clk, reset (sync, active-high); bus (debug_dump_controller_if.slave) carries
//   rx_data/rx_done_tick from the UART receiver, tx_start/tx_data/tx_done_tick to the transmitter,
//   word_idx/word_in to the snapshot mux, pipe_clk_en to the pipeline and the busy flag.
// Optional feature: define DEBUG_FRAME_HDR_EN to wrap each frame in an A5 header and an XOR checksum byte.
module debug_dump_controller #(
    parameter int         NUM_WORDS = 48,
    parameter int         IDX_BITS  = 6,
    parameter logic [7:0] CMD_STEP  = 8'h73,
    parameter logic [7:0] CMD_RUN   = 8'h72,
    parameter logic [7:0] CMD_HALT  = 8'h68,
    parameter logic [7:0] CMD_DUMP  = 8'h64
) (
    input logic clk,
    input logic reset,
    debug_dump_controller_if.slave bus
);
    typedef enum logic [2:0] {IDLE, STEP, LOAD, SEND, WAIT} state_t;
    state_t state, state_nx, wait_nx;
    logic run_mode;
    logic [31:0] shift;
    logic [1:0] byte_cnt;
    logic last_word, word_end;
    assign last_word = bus.word_idx == IDX_BITS'(NUM_WORDS - 1);
    assign word_end = byte_cnt == 2'd3;
`ifdef DEBUG_FRAME_HDR_EN
    typedef enum logic [1:0] {PH_HDR, PH_DATA, PH_CKS} phase_t;
    phase_t phase;
    logic [7:0] csum;
    localparam state_t FRAME_FIRST = SEND;
    // after the last data byte the checksum goes out through SEND/WAIT as one more byte
    assign wait_nx = phase == PH_HDR ? LOAD : phase == PH_CKS ? IDLE :
                     !word_end ? SEND : last_word ? SEND : LOAD;
`else
    localparam state_t FRAME_FIRST = LOAD;
    assign wait_nx = !word_end ? SEND : last_word ? IDLE : LOAD;
`endif
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (bus.rx_done_tick)
                      state_nx = bus.rx_data == CMD_STEP && !run_mode ? STEP :
                                 bus.rx_data == CMD_DUMP ? FRAME_FIRST : IDLE;
            STEP: state_nx = FRAME_FIRST;
            LOAD: state_nx = SEND;
            SEND: state_nx = WAIT;
            WAIT: if (bus.tx_done_tick) state_nx = wait_nx;
            default: state_nx = IDLE;
        endcase
    end
    assign bus.busy = state != IDLE;
    assign bus.pipe_clk_en = state == IDLE ? run_mode : state == STEP;
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= state_nx;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            run_mode     <= 1'b0;
            shift        <= '0;
            byte_cnt     <= '0;
            bus.word_idx <= '0;
            bus.tx_start <= 1'b0;
            bus.tx_data  <= '0;
`ifdef DEBUG_FRAME_HDR_EN
            phase <= PH_HDR;
            csum  <= '0;
`endif
        end else begin
            // tx_start is registered so it lines up with the freshly loaded tx_data
            bus.tx_start <= state == SEND;
            // halt is honoured even mid-frame; run is only taken while idle
            if (bus.rx_done_tick && bus.rx_data == CMD_HALT) run_mode <= 1'b0;
            else if (bus.rx_done_tick && bus.rx_data == CMD_RUN && state == IDLE) run_mode <= 1'b1;
            if (state == IDLE) bus.word_idx <= '0;
            if (state == LOAD) begin
                shift    <= bus.word_in;
                byte_cnt <= '0;
            end
            if (state == SEND) bus.tx_data <= shift[31:24];
`ifdef DEBUG_FRAME_HDR_EN
            if (state == SEND && phase == PH_DATA) csum <= csum ^ shift[31:24];
            if (state_nx == SEND && (state == IDLE || state == STEP)) begin
                shift <= {8'hA5, 24'h0};
                phase <= PH_HDR;
                csum  <= '0;
            end
`endif
            if (state == WAIT && bus.tx_done_tick) begin
                shift    <= shift << 8;
                byte_cnt <= byte_cnt + 2'd1;
`ifdef DEBUG_FRAME_HDR_EN
                if (phase == PH_HDR) phase <= PH_DATA;
                if (phase == PH_DATA && word_end) begin
                    bus.word_idx <= last_word ? '0 : bus.word_idx + 1'b1;
                    if (last_word) begin
                        shift <= {csum, 24'h0};
                        phase <= PH_CKS;
                    end
                end
`else
                if (word_end) bus.word_idx <= last_word ? '0 : bus.word_idx + 1'b1;
`endif
            end
        end
    end
endmodule
